// File: rtl/otter_mem_arbiter_if.sv
// Requester-side bundle for one master of the OTTER data-port arbiter.
// The master drives a held request; the arbiter returns grant and sized read data.
interface otter_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, din, size, sign,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, din, size, sign,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Shares OTTER memory data port 2 between the CPU MEM stage (a) and the loader (b).
// Writes take one cycle; reads hold the address through the synchronous read.
module otter_mem_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    otter_mem_arbiter_if.slave a,
    otter_mem_arbiter_if.slave b,
    output logic               MEM_RDEN2,
    output logic               MEM_WE2,
    output logic [31:0]        MEM_ADDR2,
    output logic [31:0]        MEM_DIN2,
    output logic [1:0]         MEM_SIZE,
    output logic               MEM_SIGN,
    input  logic [31:0]        MEM_DOUT2
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;
    localparam logic       OWN_A   = 1'b0;
    localparam logic       OWN_B   = 1'b1;

    logic [0:0]  state;
    logic        last;
    logic [31:0] hold_addr;
    logic [1:0]  hold_size;
    logic        hold_sign;
    logic        hold_owner;
    logic        idle_ok;
    logic        a_win;
    logic        b_win;
    logic        grant;

    // Pick a winner while idle; reset masks every grant.
    always_comb begin
        idle_ok = (state == ST_IDLE) && !RST;
        a_win   = idle_ok && a.req
                  && (!b.req || !RR_EN || last == OWN_B);
        b_win   = idle_ok && b.req && !a_win;
        grant   = a_win || b_win;
    end

    assign a.gnt = a_win;
    assign b.gnt = b_win;

    // Drive the memory bus from the winner, or from the hold register in RESP.
    always_comb begin
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        MEM_ADDR2 = '0;
        MEM_DIN2  = '0;
        MEM_SIZE  = '0;
        MEM_SIGN  = 1'b0;
        unique case (1'b1)
            a_win: begin
                MEM_WE2   = a.we;
                MEM_RDEN2 = !a.we;
                MEM_ADDR2 = a.addr;
                MEM_DIN2  = a.din;
                MEM_SIZE  = a.size;
                MEM_SIGN  = a.sign;
            end
            b_win: begin
                MEM_WE2   = b.we;
                MEM_RDEN2 = !b.we;
                MEM_ADDR2 = b.addr;
                MEM_DIN2  = b.din;
                MEM_SIZE  = b.size;
                MEM_SIGN  = b.sign;
            end
            (state == ST_RESP): begin
                MEM_ADDR2 = hold_addr;
                MEM_SIZE  = hold_size;
                MEM_SIGN  = hold_sign;
            end
            default: begin
                MEM_RDEN2 = 1'b0;
            end
        endcase
    end

    // Sequence grants and return the sized read data to its owner.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            last       <= OWN_B;
            hold_addr  <= '0;
            hold_size  <= '0;
            hold_sign  <= 1'b0;
            hold_owner <= OWN_A;
            a.rdata    <= '0;
            b.rdata    <= '0;
            a.rvalid   <= 1'b0;
            b.rvalid   <= 1'b0;
        end else begin
            a.rvalid <= 1'b0;
            b.rvalid <= 1'b0;
            if (state == ST_RESP) begin
                state <= ST_IDLE;
                if (hold_owner == OWN_A) begin
                    a.rdata  <= MEM_DOUT2;
                    a.rvalid <= 1'b1;
                end else begin
                    b.rdata  <= MEM_DOUT2;
                    b.rvalid <= 1'b1;
                end
            end else if (grant) begin
                last       <= b_win;
                hold_owner <= b_win;
                hold_addr  <= MEM_ADDR2;
                hold_size  <= MEM_SIZE;
                hold_sign  <= MEM_SIGN;
                if (!MEM_WE2) begin
                    state <= ST_RESP;
                end
            end
        end
    end
endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Arbiter and sequencer for the OTTER memory's data port (port 2). It shares that single port between two masters: requester A, the CPU MEM stage, and requester B, the debug/program loader. It drives the memory's read and write enables and holds address, size and sign stable across the one-cycle synchronous read. Each master gets a registered, already-sized read result. The instruction port (port 1) does not pass through this block.

## Interface
- `RR_EN`, default 1: 1 = round-robin between A and B; 0 = fixed priority, A always wins.
- `CLK` in 1: system clock, shared with memory.
- `RST` in 1: synchronous, active-high reset.
- `A_REQ` / `B_REQ` in 1: access request. Must be held, with its qualifiers stable, until the matching `_GNT`.
- `A_WE` / `B_WE` in 1: 1 = write, 0 = read.
- `A_ADDR` / `B_ADDR` in 32: byte address.
- `A_DIN` / `B_DIN` in 32: write data.
- `A_SIZE` / `B_SIZE` in 2: 0 = byte, 1 = half, 2 = word.
- `A_SIGN` / `B_SIGN` in 1: 1 = unsigned, 0 = signed.
- `A_GNT` / `B_GNT` out 1: request accepted this cycle. Combinational.
- `A_RVALID` / `B_RVALID` out 1: one-cycle pulse; `_RDATA` is valid.
- `A_RDATA` / `B_RDATA` out 32: registered read result.
- `MEM_RDEN2` out 1: memory data read enable.
- `MEM_WE2` out 1: memory data write enable.
- `MEM_ADDR2` out 32: memory data address.
- `MEM_DIN2` out 32: memory write data.
- `MEM_SIZE` out 2: memory access size.
- `MEM_SIGN` out 1: memory sign control.
- `MEM_DOUT2` in 32: memory sized read data, valid the cycle after `MEM_RDEN2`.

## Operation
- **States:**
  - IDLE: accepts a request.
  - RESP: a read is in flight; no request is accepted.
- **Selection in IDLE:**
  - Only one requester active: it wins.
  - Both active, `RR_EN`=1: the requester not granted last wins. The `last` pointer updates on every grant.
  - Both active, `RR_EN`=0: A wins.
  - `last` resets to B, so A wins the first contention.
- **Grant in IDLE:** the winner's `_GNT`=1 and its fields drive the `MEM_*` bus combinationally. The accepted fields and the owner ID are captured into a hold register.
- **Write grant:**
  - `MEM_WE2`=1 for exactly that cycle.
  - State stays IDLE, so back-to-back writes run one per cycle.
  - No `_RVALID` is produced for a write.
- **Read grant:**
  - `MEM_RDEN2`=1 for that cycle, then state goes to RESP.
- **RESP:**
  - `MEM_ADDR2`/`MEM_SIZE`/`MEM_SIGN` are driven from the hold register. This is required because the memory sizes and routes MMIO using the current address.
  - `MEM_RDEN2`=0, `MEM_WE2`=0.
  - `MEM_DOUT2` is captured into the owner's `_RDATA` at the end of the cycle. State returns to IDLE.
- **Read completion:** next cycle, the owner's `_RVALID`=1 for one cycle. A new grant may occur in that same cycle.
- **Idle bus (no grant, IDLE):** all `MEM_*` outputs are 0.
- **Width and format rules:** all arithmetic is pass-through; the block does no sizing itself. Misaligned or unsupported size/offset combinations are forwarded unchanged; the memory returns 0.
- **MMIO:** addresses ≥ 0x00010000 follow the identical protocol. The IO buffer is loaded by the same `MEM_RDEN2` pulse.

## Timing
- **Reset** (`RST`=1 at the clock edge):
  - State = IDLE, `last` = B.
  - Hold register cleared.
  - `A_RDATA`/`B_RDATA` = 0, all `_RVALID` = 0.
  - While `RST` is high, all `_GNT`, `MEM_RDEN2` and `MEM_WE2` are forced to 0.
- **Read latency:** grant at cycle N, memory data at N+1, `_RVALID` at N+2.
- **Throughput:**
  - Reads: at most one every 2 cycles.
  - Writes: one per cycle.
- **Request arriving during RESP:** waits. It is granted in the following IDLE cycle.
- **Reset during RESP:** the read is abandoned and no `_RVALID` is issued. `_RDATA` is cleared.
- **`_GNT` vs `_REQ`:** `_GNT` is never asserted without `_REQ` in the same cycle.
- **Requester behaviour after grant:** a requester may drop `_REQ` or present a new request in the cycle after its `_GNT`.

## Test plan
1. **Single read:** after reset, preload word 0x0000100 = 0x8899AABB. A reads address 0x100, size 2.
   - `A_GNT` and `MEM_RDEN2` at N.
   - `MEM_ADDR2` = 0x100 held through N+1.
   - `A_RVALID` at N+2 with `A_RDATA` = 0x8899AABB.
   - B signals stay 0.
2. **Signed byte read:** B reads address 0x103, size 0, sign 0, with byte = 0xF0.
   - `B_RDATA` = 0xFFFFFFF0 at N+2.
   - `MEM_SIZE` = 0 and `MEM_ADDR2` = 0x103 held through N+1.
3. **Contention, `RR_EN`=1:** A and B both hold read requests.
   - Grants go A (cycle 0), B (cycle 2), A (cycle 4).
   - `RVALID` pulses at cycles 2, 4, 6 for the matching owner only.
4. **Fixed priority, `RR_EN`=0:** both request continuously.
   - B never granted while `A_REQ`=1.
   - B granted in the first IDLE cycle after A drops.
5. **Back-to-back writes:** A issues sw to 0x200 = 0x11111111, then sb to 0x201 = 0x22, in consecutive cycles.
   - `MEM_WE2` is high for 2 consecutive cycles.
   - A subsequent read of 0x200 returns 0x11112211.
6. **Reset mid-read:** B read granted, then `RST`=1 during RESP.
   - No `B_RVALID`, `B_RDATA` = 0.
   - The next A request after reset is granted first.
